// File: rtl/dcache_direct.sv
// Direct-mapped write-back, write-allocate data cache between the MEM stage and a block-wide memory.
// Optional `DCACHE_STATS_EN adds hit/miss completion counters.
module dcache_direct #(
  parameter int LINE_COUNT  = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         is_input_valid,
  input  logic [31:0]  addr,
  input  logic         mem_rw,
  input  logic [31:0]  din,
  output logic         is_ready,
  output logic         is_output_valid,
  output logic [31:0]  dout,
  output logic         is_hit,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
`ifdef DCACHE_STATS_EN
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
`endif
  output logic [1:0]   dbg_state
);
  localparam int IDX_W  = $clog2(LINE_COUNT);
  localparam int TAG_W  = 32 - IDX_W - 4;
  localparam int LINE_W = 32 * BLOCK_WORDS;

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_din_q, req_din_d;
  logic        req_rw_q, req_rw_d;
  logic        miss_q, miss_d;

  logic [LINE_COUNT-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q [LINE_COUNT];
  logic [LINE_W-1:0]     data_q [LINE_COUNT];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag, cur_tag, tag_d;
  logic [1:0]        req_word;
  logic [LINE_W-1:0] cur_line, store_line, line_d;
  logic [31:0]       sel_word;
  logic              line_hit, line_we;
  logic              unused_addr_lsb;

  assign req_idx         = req_addr_q[IDX_W+3:4];
  assign req_tag         = req_addr_q[31:IDX_W+4];
  assign req_word        = req_addr_q[3:2];
  assign unused_addr_lsb = ^req_addr_q[1:0];
  assign cur_line        = data_q[req_idx];
  assign cur_tag         = tag_q[req_idx];
  assign line_hit        = valid_q[req_idx] && (cur_tag == req_tag);

  always_comb begin
    sel_word   = cur_line[31:0];
    store_line = cur_line;
    case (req_word)
      2'd0: begin sel_word = cur_line[31:0];   store_line[31:0]   = req_din_q; end
      2'd1: begin sel_word = cur_line[63:32];  store_line[63:32]  = req_din_q; end
      2'd2: begin sel_word = cur_line[95:64];  store_line[95:64]  = req_din_q; end
      default: begin sel_word = cur_line[127:96]; store_line[127:96] = req_din_q; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_din_d  = req_din_q;
    req_rw_d   = req_rw_q;
    miss_d     = miss_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    line_we    = 1'b0;
    line_d     = store_line;
    tag_d      = req_tag;
    case (state_q)
      S_IDLE: begin
        if (is_input_valid) begin
          req_addr_d = addr;
          req_din_d  = din;
          req_rw_d   = mem_rw;
          miss_d     = 1'b0;
          state_d    = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (line_hit) begin
          if (req_rw_q) begin
            line_we          = 1'b1;
            dirty_d[req_idx] = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          miss_d  = 1'b1;
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        // Refill lands here; the retry in COMPARE then hits and merges any store.
        if (mem_ready) begin
          line_we          = 1'b1;
          line_d           = mem_rdata;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          state_d          = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      req_din_q  <= '0;
      req_rw_q   <= 1'b0;
      miss_q     <= 1'b0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_din_q  <= req_din_d;
      req_rw_q   <= req_rw_d;
      miss_q     <= miss_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
    end
  end

  // Tag/data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[req_idx] <= line_d;
      tag_q[req_idx]  <= tag_d;
    end
  end

  assign is_ready        = (state_q == S_IDLE);
  assign is_output_valid = (state_q == S_COMPARE) && line_hit;
  assign dout            = is_output_valid ? sel_word : 32'h0;
  assign is_hit          = is_output_valid && !miss_q;
  assign mem_req         = (state_q == S_WRITEBACK) || (state_q == S_ALLOCATE);
  assign mem_we          = (state_q == S_WRITEBACK);
  assign mem_addr        = (state_q == S_WRITEBACK) ? {cur_tag, req_idx, 4'b0} :
                           (state_q == S_ALLOCATE)  ? {req_tag, req_idx, 4'b0} : 32'h0;
  assign mem_wdata       = (state_q == S_WRITEBACK) ? cur_line : '0;
  assign dbg_state       = state_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (is_output_valid) begin
      if (is_hit) hit_count_d  = hit_count_q + 32'd1;
      else        miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: doc/dcache_direct.md
# dcache_direct

Direct-mapped, write-back, write-allocate data cache between the pipelined CPU's MEM stage and a multi-cycle block-wide data memory. It accepts one word load/store at a time from the MEM stage and serves hits from its own arrays. On a miss it writes back a dirty victim block if needed, then refills the block from memory before completing. The MEM stage stalls the pipeline while `is_ready` is low or a request is outstanding.

## Interface
Parameters:
- `LINE_COUNT`, 16: number of cache lines (power of 2, ≥2); `IDX_W = log2(LINE_COUNT)`.
- `BLOCK_WORDS`, 4: 32-bit words per line, fixed at 4 (16-byte block, 128-bit memory bus).

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `is_input_valid` input 1: CPU request present.
- `addr` input 32: byte address; `[1:0]` ignored, `[3:2]` word offset, `[IDX_W+3:4]` index, `[31:IDX_W+4]` tag.
- `mem_rw` input 1: 0 = load, 1 = store.
- `din` input 32: store data.
- `is_ready` output 1: cache idle, can accept a request.
- `is_output_valid` output 1: one-cycle completion pulse.
- `dout` output 32: load data, valid only with `is_output_valid`.
- `is_hit` output 1: qualifies the completing request; 1 = hit on first lookup.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 = block write (writeback), 0 = block read (refill).
- `mem_addr` output 32: block-aligned address, `[3:0]=0`.
- `mem_wdata` output 128: writeback block, word 0 in `[31:0]`.
- `mem_rdata` input 128: refill block, same word order.
- `mem_ready` input 1: one-cycle pulse; completes the current memory request.

## Operation
- Per line: valid bit, dirty bit, tag, and 4-word data block.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: `is_ready=1`. If `is_input_valid`, latch addr/mem_rw/din, clear the miss flag, and go to COMPARE. Input is ignored in all other states.
- COMPARE, hit (valid && tag match):
  - Load: `dout` = selected word.
  - Store: write `din` into the word and set dirty.
  - Pulse `is_output_valid`; `is_hit` = !miss flag; go to IDLE.
- COMPARE, miss: set the miss flag. Go to WRITEBACK if the line is valid and dirty, else go to ALLOCATE.
- WRITEBACK: `mem_req=1`, `mem_we=1`, `mem_addr={old tag, index, 4'b0}`, `mem_wdata` = line. On `mem_ready`, go to ALLOCATE.
- ALLOCATE: `mem_req=1`, `mem_we=0`, `mem_addr={req tag, index, 4'b0}`. On `mem_ready`, write `mem_rdata` into the line, set valid, clear dirty, load the tag, and go to COMPARE. The retry now hits and completes with `is_hit=0`.
- A store miss allocates and then merges the store in COMPARE; the line ends dirty.
- `mem_ready` is ignored when `mem_req=0`.
- The memory request holds with stable `mem_addr`/`mem_wdata` until `mem_ready`, with no timeout.
- Reset mid-operation: state returns to IDLE and all valid/dirty bits clear. Dirty data is discarded; no writeback occurs.

## Timing
- Reset values:
  - `is_ready=1`
  - `is_output_valid=0`, `dout=0`, `is_hit=0`
  - `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`
  - state IDLE, all valid/dirty = 0
- All outputs are decoded from the registered state and latched request; `dout` is forced to 0 when `is_output_valid=0`.
- Hit: accepted at edge T; `is_output_valid` high during cycle T+1; `is_ready` high again at T+2. Throughput is one request per 2 cycles.
- Clean miss: 2 + L + 1 cycles from accept to completion, where L is the cycles from `mem_req` rise to `mem_ready`.
- Dirty miss: clean-miss latency + L_wb + 1 cycles.
- `mem_req` drops in the cycle after `mem_ready` is sampled. WRITEBACK→ALLOCATE deasserts `mem_req` for 0 cycles; the address changes in place.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds outputs `hit_count[31:0]` and `miss_count[31:0]`, both reset to 0.
  - Each increments once per completion (`is_output_valid`), selected by `is_hit`; both wrap at 2^32.
- Not defined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- Cold load of `0x00000040` after reset, memory returns word1=`0x11112222` with L=4: ALLOCATE `mem_addr=0x40`, completion with `is_hit=0`. A load of `0x00000044` next completes at T+1 with `dout=0x11112222`, `is_hit=1`.
- Store `0xDEADBEEF` to `0x40` (hit), then load `0x00000140` (index 4, new tag): WRITEBACK with `mem_addr=0x40`, `mem_wdata[31:0]=0xDEADBEEF`, then ALLOCATE with `mem_addr=0x140`, completion with `is_hit=0`.
- Hold `mem_ready=0` for 20 cycles during ALLOCATE: `mem_req`, `mem_addr`, `mem_we` stay stable; `is_ready=0`; no `is_output_valid`.
- Assert `reset` mid-ALLOCATE: `mem_req=0` in the same cycle. After release, a load of the same address misses again (`is_hit=0`).
- With `DCACHE_STATS_EN`, run the sequence miss, hit, hit, store-hit, miss: `hit_count=3`, `miss_count=2`.
- Drive `is_input_valid` with varying `addr` while busy: the request is ignored, and the completion reflects only the latched request.
